// File: rtl/ex_branch_ctrl.sv
// Execute-stage branch resolution: registered PC redirect, IF/ID squash for
// FLUSH_CYCLES advancing cycles, misaligned-target flag and branch statistics.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | no redirect in flight; EX branches/jumps are resolved
// ST_REDIRECT | pc_sel asserted for one advancing cycle, IF/ID squashed
// ST_FLUSH    | remaining FLUSH_CYCLES-1 squash cycles, EX inputs ignored
module ex_branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        EX_valid,
  input  logic        EX_branch,
  input  logic        EX_jump,
  input  logic        EX_cond,
  input  logic [31:0] EX_bpc,
  input  logic [31:0] EX_npc,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        IF_flush,
  output logic        ID_flush,
  output logic        addr_err,
  output logic        br_busy,
  output logic [15:0] br_cnt,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        resolve, taken, misaligned, accept, npc_tap;
  logic        pc_sel_nxt, flush_nxt, addr_err_nxt;
  logic [31:0] pc_target_nxt;
  logic [15:0] br_cnt_nxt, taken_cnt_nxt;

  // The fall-through PC is only a debug tap; fold it in as a tautology so it
  // stays a live input without affecting behaviour.
  assign npc_tap    = (^EX_npc) | 1'b1;
  assign resolve    = (state == ST_IDLE) & EX_valid & (EX_branch | EX_jump) & ~stall & npc_tap;
  assign taken      = resolve & (EX_jump | EX_cond);
  assign misaligned = |EX_bpc[1:0];
  assign accept     = taken & ~misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pc_sel    <= 1'b0;
      IF_flush  <= 1'b0;
      ID_flush  <= 1'b0;
      br_busy   <= 1'b0;
      addr_err  <= 1'b0;
      pc_target <= '0;
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pc_sel    <= pc_sel_nxt;
      IF_flush  <= flush_nxt;
      ID_flush  <= flush_nxt;
      br_busy   <= flush_nxt;
      addr_err  <= addr_err_nxt;
      pc_target <= pc_target_nxt;
      br_cnt    <= br_cnt_nxt;
      taken_cnt <= taken_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (accept) state_nxt = ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (FLUSH_CYCLES <= 1) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = 4'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; under stall state_nxt == state,
  // so every output naturally holds.
  always_comb begin
    pc_sel_nxt    = (state_nxt == ST_REDIRECT);
    flush_nxt     = (state_nxt != ST_IDLE);
    addr_err_nxt  = stall ? addr_err : (taken & misaligned);
    pc_target_nxt = accept ? EX_bpc : pc_target;
    br_cnt_nxt    = resolve ? br_cnt + 16'd1 : br_cnt;
    taken_cnt_nxt = accept ? taken_cnt + 16'd1 : taken_cnt;
  end

endmodule
